// File: rtl/w_align_stage_pkg.sv
// Shared types and helpers for the store-side W-beat aligner.
// Feature macro W_ALIGN_OUT_REG_EN (used in w_align_stage) adds an output register stage.
package w_align_stage_pkg;

  localparam int unsigned WAlignOffW    = 8;
  localparam int unsigned WAlignNBytesW = 32;
  localparam int unsigned WAlignSumW    = WAlignNBytesW + 2;

  typedef enum logic [1:0] {
    WA_IDLE,
    WA_STREAM,
    WA_FLUSH
  } w_align_state_e;

  typedef struct packed {
    logic [WAlignOffW-1:0]    offset;
    logic [WAlignNBytesW-1:0] nbytes;
  } w_align_cmd_t;

  // Output beat count ceil((o+n)/B) where lb = log2(B); wide enough that o+n cannot wrap.
  function automatic logic [WAlignSumW-1:0] w_align_beats(
    input logic [WAlignOffW-1:0]    o,
    input logic [WAlignNBytesW-1:0] n,
    input int unsigned              lb
  );
    logic [WAlignSumW-1:0] sum;
    sum = WAlignSumW'(o) + WAlignSumW'(n) + (WAlignSumW'(1) << lb) - WAlignSumW'(1);
    return sum >> lb;
  endfunction

endpackage

// File: rtl/w_align_stage_byte_rotate.sv
// Byte-granular left rotator: output lane j takes input byte (j - shift) mod B.
// Built as log2(B) conditional stages, one per shift bit.
module w_byte_rotate #(
  parameter int unsigned AxiDataWidth = 512,
  localparam int unsigned B   = AxiDataWidth / 8,
  localparam int unsigned ShW = $clog2(B)
) (
  input  logic [AxiDataWidth-1:0] data_i,
  input  logic [ShW-1:0]          shift_i,
  output logic [AxiDataWidth-1:0] data_o
);

  always_comb begin : rot_comb
    logic [AxiDataWidth-1:0] acc;
    acc = data_i;
    for (int s = 0; s < ShW; s++) begin
      if (shift_i[s]) begin
        acc = (acc << (8 << s)) | (acc >> (AxiDataWidth - (8 << s)));
      end
    end
    data_o = acc;
  end

endmodule

// File: rtl/w_align_stage.sv
// W-path store aligner: moves lane-0-packed store bytes to the burst start offset,
// generates WSTRB/WLAST and emits a flush beat for spill-over. Option: W_ALIGN_OUT_REG_EN.
module w_align_stage
  import w_align_stage_pkg::*;
#(
  parameter int unsigned AxiDataWidth = 512,
  parameter int unsigned NumTrackers  = 8,
  parameter int unsigned NBytesWidth  = 32,
  localparam int unsigned B    = AxiDataWidth / 8,
  localparam int unsigned OffW = $clog2(B)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [OffW-1:0]         cmd_offset_i,
  input  logic [NBytesWidth-1:0]  cmd_nbytes_i,
  input  logic                    in_w_valid_i,
  output logic                    in_w_ready_o,
  input  logic [AxiDataWidth-1:0] in_w_data_i,
  output logic                    out_w_valid_o,
  input  logic                    out_w_ready_i,
  output logic [AxiDataWidth-1:0] out_w_data_o,
  output logic [B-1:0]            out_w_strb_o,
  output logic                    out_w_last_o
);

  localparam int unsigned PtrW  = $clog2(NumTrackers);
  localparam int unsigned CntW  = $clog2(NumTrackers + 1);
  localparam int unsigned BeatW = NBytesWidth + 1;

  w_align_cmd_t     mem_q [NumTrackers];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             push, pop, full, empty;
  w_align_cmd_t     head;
  logic [OffW-1:0]        head_off;
  logic [NBytesWidth-1:0] head_nbytes;
  logic [BeatW-1:0]       head_in_beats, head_out_beats;

  w_align_state_e         state_q;
  logic [OffW-1:0]        off_q;
  logic [NBytesWidth-1:0] nbytes_q;
  logic [BeatW-1:0]       in_beats_q, out_beats_q, k_q;
  logic [AxiDataWidth-1:0] carry_q;

  logic [AxiDataWidth-1:0] rot;
  logic [BeatW-1:0]        base, off_ext, end_ext;
  logic                    algn_valid, algn_ready, algn_hs, algn_last;
  logic [AxiDataWidth-1:0] algn_data;
  logic [B-1:0]            algn_strb;

  assign full        = (cnt_q == CntW'(NumTrackers));
  assign empty       = (cnt_q == '0);
  assign cmd_ready_o = !full;
  assign push        = cmd_valid_i && !full;
  assign pop         = (state_q == WA_IDLE) && !empty;
  assign head        = mem_q[rd_ptr_q];

  assign head_off       = OffW'(head.offset);
  assign head_nbytes    = NBytesWidth'(head.nbytes);
  assign head_in_beats  = (BeatW'(head_nbytes) + BeatW'(B - 1)) >> OffW;
  assign head_out_beats = BeatW'(w_align_beats(head.offset, head.nbytes, OffW));

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{offset: WAlignOffW'(cmd_offset_i), nbytes: WAlignNBytesW'(cmd_nbytes_i)};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == PtrW'(NumTrackers - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == PtrW'(NumTrackers - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      if (push && !pop)      cnt_q <= cnt_q + CntW'(1);
      else if (pop && !push) cnt_q <= cnt_q - CntW'(1);
    end
  end

  w_byte_rotate #(.AxiDataWidth(AxiDataWidth)) i_rotate (
    .data_i  (in_w_data_i),
    .shift_i (off_q),
    .data_o  (rot)
  );

  assign algn_valid   = (state_q == WA_STREAM) ? in_w_valid_i : (state_q == WA_FLUSH);
  assign in_w_ready_o = (state_q == WA_STREAM) && algn_ready;
  assign algn_hs      = (state_q == WA_STREAM) && in_w_valid_i && algn_ready;

  // Zero-length commands are consumed in IDLE without ever entering STREAM.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= WA_IDLE;
      off_q       <= '0;
      nbytes_q    <= '0;
      in_beats_q  <= '0;
      out_beats_q <= '0;
      k_q         <= '0;
      carry_q     <= '0;
    end else begin
      case (state_q)
        WA_IDLE: begin
          if (!empty) begin
            k_q     <= '0;
            carry_q <= '0;
            if (head_nbytes != '0) begin
              off_q       <= head_off;
              nbytes_q    <= head_nbytes;
              in_beats_q  <= head_in_beats;
              out_beats_q <= head_out_beats;
              state_q     <= WA_STREAM;
            end
          end
        end
        WA_STREAM: begin
          if (algn_hs) begin
            carry_q <= rot;
            k_q     <= k_q + BeatW'(1);
            if (k_q == in_beats_q - BeatW'(1)) begin
              state_q <= (out_beats_q > in_beats_q) ? WA_FLUSH : WA_IDLE;
            end
          end
        end
        WA_FLUSH: begin
          if (algn_ready) state_q <= WA_IDLE;
        end
        default: state_q <= WA_IDLE;
      endcase
    end
  end

  assign base    = k_q << OffW;
  assign off_ext = BeatW'(off_q);
  assign end_ext = off_ext + BeatW'(nbytes_q);

  always_comb begin
    algn_data = '0;
    algn_strb = '0;
    algn_last = 1'b0;
    if (state_q != WA_IDLE) begin
      for (int j = 0; j < B; j++) begin
        if (OffW'(j) < off_q)            algn_data[8*j +: 8] = carry_q[8*j +: 8];
        else if (state_q == WA_STREAM)   algn_data[8*j +: 8] = rot[8*j +: 8];
        algn_strb[j] = ((base + BeatW'(j)) >= off_ext) && ((base + BeatW'(j)) < end_ext);
      end
      algn_last = (k_q == out_beats_q - BeatW'(1));
    end
  end

`ifdef W_ALIGN_OUT_REG_EN
  logic                    out_valid_q;
  logic [AxiDataWidth-1:0] out_data_q;
  logic [B-1:0]            out_strb_q;
  logic                    out_last_q;

  assign algn_ready = !out_valid_q || out_w_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_strb_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (algn_ready) begin
      out_valid_q <= algn_valid;
      if (algn_valid) begin
        out_data_q <= algn_data;
        out_strb_q <= algn_strb;
        out_last_q <= algn_last;
      end
    end
  end

  assign out_w_valid_o = out_valid_q;
  assign out_w_data_o  = out_data_q;
  assign out_w_strb_o  = out_strb_q;
  assign out_w_last_o  = out_last_q;
`else
  assign algn_ready    = out_w_ready_i;
  assign out_w_valid_o = algn_valid;
  assign out_w_data_o  = algn_data;
  assign out_w_strb_o  = algn_strb;
  assign out_w_last_o  = algn_last;
`endif

endmodule

// File: tb/tb_w_align_stage.sv
// Directed bench for w_align_stage at AxiDataWidth=128 (16 byte lanes).
module tb_w_align_stage;

  localparam logic [127:0] BEAT0 = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] BEAT1 = 128'h1f1e1d1c1b1a19181716151413121110;

  logic         clk, rst_n;
  logic         cmd_valid, cmd_ready;
  logic [3:0]   cmd_offset;
  logic [31:0]  cmd_nbytes;
  logic         in_valid, in_ready;
  logic [127:0] in_data;
  logic         out_valid, out_ready;
  logic [127:0] out_data;
  logic [15:0]  out_strb;
  logic         out_last;

  int checks = 0;
  int failures = 0;
  int in_idx, out_cnt, nbytes_seen, berr, viol, p;
  logic exp_s;

  w_align_stage #(.AxiDataWidth(128), .NumTrackers(8), .NBytesWidth(32)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_offset_i  (cmd_offset),
    .cmd_nbytes_i  (cmd_nbytes),
    .in_w_valid_i  (in_valid),
    .in_w_ready_o  (in_ready),
    .in_w_data_i   (in_data),
    .out_w_valid_o (out_valid),
    .out_w_ready_i (out_ready),
    .out_w_data_o  (out_data),
    .out_w_strb_o  (out_strb),
    .out_w_last_o  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] o, input logic [31:0] n);
    cmd_offset = o;
    cmd_nbytes = n;
    cmd_valid  = 1'b1;
    @(negedge clk);
    cmd_valid  = 1'b0;
  endtask

  function automatic logic [127:0] t4_beat(input int idx);
    logic [127:0] d;
    for (int b = 0; b < 16; b++) d[8*b +: 8] = 8'(32'h40 + idx * 16 + b);
    return d;
  endfunction

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_offset = '0; cmd_nbytes = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_cmd_ready", 128'(cmd_ready), 128'(1));
    check("rst_in_ready",  128'(in_ready),  128'(0));
    check("rst_data",      out_data,        128'(0));
    check("rst_strb",      128'(out_strb),  128'(0));
    check("rst_last",      128'(out_last),  128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // o=0, n=32: straight pass-through, two beats, no flush
    push(4'd0, 32'd32);
    @(negedge clk);
    in_valid = 1'b1; in_data = BEAT0; out_ready = 1'b1;
    #1;
    check("t1_b0_valid", 128'(out_valid), 128'(1));
    check("t1_b0_ready", 128'(in_ready),  128'(1));
    check("t1_b0_data",  out_data,        BEAT0);
    check("t1_b0_strb",  128'(out_strb),  128'(16'hffff));
    check("t1_b0_last",  128'(out_last),  128'(0));
    @(negedge clk);
    in_data = BEAT1;
    #1;
    check("t1_b1_data",  out_data,        BEAT1);
    check("t1_b1_strb",  128'(out_strb),  128'(16'hffff));
    check("t1_b1_last",  128'(out_last),  128'(1));
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("t1_no_flush", 128'(out_valid), 128'(0));

    // o=3, n=16: one input beat spills 3 bytes into a flush beat
    push(4'd3, 32'd16);
    @(negedge clk);
    in_valid = 1'b1; in_data = BEAT0;
    #1;
    check("t2_b0_data", out_data,       128'h0c0b0a09080706050403020100000000);
    check("t2_b0_strb", 128'(out_strb), 128'(16'hfff8));
    check("t2_b0_last", 128'(out_last), 128'(0));
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("t2_fl_valid", 128'(out_valid), 128'(1));
    check("t2_fl_ready", 128'(in_ready),  128'(0));
    check("t2_fl_data",  out_data,        128'h0f0e0d);
    check("t2_fl_strb",  128'(out_strb),  128'(16'h0007));
    check("t2_fl_last",  128'(out_last),  128'(1));
    @(negedge clk);
    #1;
    check("t2_done", 128'(out_valid), 128'(0));

    // o=5, n=8: fits in one beat
    push(4'd5, 32'd8);
    @(negedge clk);
    in_valid = 1'b1; in_data = BEAT0;
    #1;
    check("t3_data", out_data,       128'h0a090807060504030201000000000000);
    check("t3_strb", 128'(out_strb), 128'(16'h1fe0));
    check("t3_last", 128'(out_last), 128'(1));
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("t3_no_flush", 128'(out_valid), 128'(0));

    // o=7, n=40 under random backpressure: ceil(47/16)=3 output beats
    push(4'd7, 32'd40);
    in_idx = 0; out_cnt = 0; nbytes_seen = 0; berr = 0; viol = 0;
    for (int cyc = 0; cyc < 300 && out_cnt < 3; cyc++) begin
      in_valid  = (in_idx < 3);
      in_data   = t4_beat(in_idx);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (!out_ready && in_ready) viol++;
      if (out_valid && out_ready) begin
        for (int j = 0; j < 16; j++) begin
          p = out_cnt * 16 + j;
          exp_s = (p >= 7) && (p < 47);
          if (out_strb[j] !== exp_s) berr++;
          else if (exp_s) begin
            if (out_data[8*j +: 8] !== 8'(32'h40 + p - 7)) berr++;
            nbytes_seen++;
          end
        end
        if (out_last !== (out_cnt == 2)) berr++;
        out_cnt++;
      end
      if (in_valid && in_ready) in_idx++;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("t4_out_beats", 128'(out_cnt),     128'(3));
    check("t4_in_beats",  128'(in_idx),      128'(3));
    check("t4_bytes",     128'(nbytes_seen), 128'(40));
    check("t4_byte_errs", 128'(berr),        128'(0));
    check("t4_ready_viol", 128'(viol),       128'(0));

    // Fill the queue behind an active burst, then free one slot
    push(4'd0, 32'd16);
    @(negedge clk);
    for (int i = 0; i < 8; i++) push(4'd0, 32'd32);
    #1;
    check("q_full", 128'(cmd_ready), 128'(0));
    in_valid = 1'b1; in_data = BEAT0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("q_pop_frees", 128'(cmd_ready), 128'(1));
    push(4'd0, 32'd32);
    #1;
    check("q_refill_full", 128'(cmd_ready), 128'(0));

    // Reset in the middle of a two-beat burst
    in_valid = 1'b1; in_data = BEAT0;
    #1;
    check("mid_valid", 128'(out_valid), 128'(1));
    check("mid_strb",  128'(out_strb),  128'(16'hffff));
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 128'(out_valid), 128'(0));
    check("arst_cmd_ready", 128'(cmd_ready), 128'(1));
    check("arst_in_ready",  128'(in_ready),  128'(0));
    check("arst_data",      out_data,        128'(0));
    check("arst_strb",      128'(out_strb),  128'(0));
    check("arst_last",      128'(out_last),  128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push(4'd5, 32'd8);
    @(negedge clk);
    in_valid = 1'b1; in_data = BEAT0;
    #1;
    check("post_rst_valid", 128'(out_valid), 128'(1));
    check("post_rst_data",  out_data,        128'h0a090807060504030201000000000000);
    check("post_rst_strb",  128'(out_strb),  128'(16'h1fe0));
    check("post_rst_last",  128'(out_last),  128'(1));
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("post_rst_idle", 128'(out_valid), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
